ts_readout_arbiter: RTL and testbench

- Round-robin arbiter that merges the 32-bit output streams of several timestamp/readout cores into one downstream FIFO write port.
- Sits in the BUS_CLK domain, between the cores' FIFO_READ/FIFO_EMPTY/FIFO_DATA ports and the shared readout FIFO.
- Keeps each core's multi-word records (e.g. low/high timestamp word pair) contiguous.
- Bounds how long a single source can hold the output.

---
 rtl/ts_readout_arbiter_pkg.sv | 21 ++
 rtl/ts_readout_arbiter_rr_pick.sv | 31 +++
 rtl/ts_readout_arbiter.sv | 150 +++++++++++++++
 tb/tb_ts_readout_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ts_readout_arbiter_pkg.sv
// Shared types and sizing helpers for the timestamp readout arbiter and its pick logic.
package ts_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } arb_state_e;

  localparam int ID_W             = 3;
  localparam int SPLIT_W          = 8;
  localparam logic [SPLIT_W-1:0] SPLIT_MAX = 8'hFF;
  localparam int DEF_MAX_BURST    = 16;
  localparam int DEF_HOLD_TIMEOUT = 255;

  // Bits needed to hold every value 0..max_val.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ts_readout_arbiter_rr_pick.sv
// Combinational rotating priority encoder: first set request at or above ptr, wrapping modulo N.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  localparam int SW = IDX_W + 1;

  logic [N-1:0]  rot;
  logic [SW-1:0] sum;

  // Rotate so bit 0 is the pointer position; the lowest surviving hit wins.
  always_comb begin
    rot   = N'({req, req} >> ptr);
    idx   = '0;
    valid = 1'b0;
    sum   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum   = {1'b0, ptr} + SW'(k);
      sum   = (sum >= SW'(N)) ? (sum - SW'(N)) : sum;
      idx   = rot[k] ? sum[IDX_W-1:0] : idx;
      valid = rot[k] ? 1'b1 : valid;
    end
  end

endmodule

// File: rtl/ts_readout_arbiter.sv
// Round-robin merge of FWFT readout streams into one FIFO write port, keeping
// ATOMIC-word records contiguous and bounding each grant to MAX_BURST words.
module ts_readout_arbiter
  import ts_arb_pkg::*;
#(
  parameter int N_SRC        = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int ATOMIC       = 2,
  parameter int MAX_BURST    = DEF_MAX_BURST,
  parameter int HOLD_TIMEOUT = DEF_HOLD_TIMEOUT
) (
  input  logic                        BUS_CLK,
  input  logic                        BUS_RST,
  input  logic [N_SRC-1:0]            SRC_EN,
  input  logic [N_SRC-1:0]            SRC_EMPTY,
  input  logic [N_SRC*DATA_WIDTH-1:0] SRC_DATA,
  output logic [N_SRC-1:0]            SRC_READ,
  input  logic                        OUT_FULL,
  output logic                        OUT_WRITE,
  output logic [DATA_WIDTH-1:0]       OUT_DATA,
  output logic [ID_W-1:0]             GRANT_ID,
  output logic                        BUSY,
  output logic [SPLIT_W-1:0]          SPLIT_CNT
);

  localparam int BURST_W = cnt_width(MAX_BURST);
  localparam int HOLD_W  = cnt_width(HOLD_TIMEOUT);

  arb_state_e            state, state_nxt;
  logic [ID_W-1:0]       rr_ptr, pick_idx, next_ptr;
  logic                  pick_valid;
  logic [BURST_W-1:0]    burst_cnt;
  logic [HOLD_W-1:0]     hold_cnt;
  logic [N_SRC-1:0]      req, sel_mask;
  logic                  cur_en, cur_empty, cur_req, rd;
  logic                  mid_record, last_word, release_now, split_now, hold_tick;
  logic [DATA_WIDTH-1:0] cur_data;

  assign req        = SRC_EN & ~SRC_EMPTY;
  assign sel_mask   = N_SRC'(1'b1) << GRANT_ID;
  assign cur_en     = |(SRC_EN & sel_mask);
  assign cur_empty  = |(SRC_EMPTY & sel_mask);
  assign cur_req    = cur_en & ~cur_empty;
  assign cur_data   = DATA_WIDTH'(SRC_DATA >> (32'(GRANT_ID) * DATA_WIDTH));
  assign mid_record = (burst_cnt % BURST_W'(ATOMIC)) != '0;
  assign last_word  = burst_cnt == BURST_W'(MAX_BURST - 1);
  assign next_ptr   = (GRANT_ID == ID_W'(N_SRC - 1)) ? '0 : (GRANT_ID + ID_W'(1));

  rr_pick #(
    .N     (N_SRC),
    .IDX_W (ID_W)
  ) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // State register.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and release/split decisions.
  always_comb begin
    state_nxt   = state;
    release_now = 1'b0;
    split_now   = 1'b0;
    hold_tick   = 1'b0;
    case (state)
      IDLE: state_nxt = pick_valid ? GRANT : IDLE;
      GRANT: begin
        if (!cur_en) begin
          release_now = 1'b1;
          split_now   = mid_record;
        end else if (rd) begin
          release_now = last_word;
        end else if (cur_empty) begin
          state_nxt   = mid_record ? HOLD : GRANT;
          release_now = ~mid_record;
        end else begin
          state_nxt = GRANT;
        end
      end
      HOLD: begin
        if (!cur_en) begin
          release_now = 1'b1;
          split_now   = 1'b1;
        end else if (!cur_empty) begin
          state_nxt   = GRANT;
          release_now = rd & last_word;
        end else if (hold_cnt == HOLD_W'(HOLD_TIMEOUT)) begin
          release_now = 1'b1;
          split_now   = 1'b1;
        end else begin
          hold_tick = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (release_now) begin
      state_nxt = IDLE;
    end else begin
      state_nxt = state_nxt;
    end
  end

  // Pop strobe and busy flag; reads are legal in HOLD as soon as data reappears.
  always_comb begin
    rd       = (state != IDLE) & cur_req & ~OUT_FULL;
    SRC_READ = rd ? sel_mask : '0;
    BUSY     = state != IDLE;
  end

  // Output word register, grant bookkeeping and counters.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      OUT_WRITE <= 1'b0;
      OUT_DATA  <= '0;
      GRANT_ID  <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      hold_cnt  <= '0;
      SPLIT_CNT <= '0;
    end else begin
      OUT_WRITE <= rd;
      OUT_DATA  <= rd ? cur_data : OUT_DATA;
      if (state == IDLE && pick_valid) begin
        GRANT_ID  <= pick_idx;
        burst_cnt <= '0;
      end else if (rd) begin
        burst_cnt <= burst_cnt + BURST_W'(1);
      end else begin
        burst_cnt <= burst_cnt;
      end
      rr_ptr   <= release_now ? next_ptr : rr_ptr;
      hold_cnt <= (state != HOLD) ? '0 : (hold_tick ? hold_cnt + HOLD_W'(1) : hold_cnt);
      if (split_now && SPLIT_CNT != SPLIT_MAX) begin
        SPLIT_CNT <= SPLIT_CNT + SPLIT_W'(1);
      end else begin
        SPLIT_CNT <= SPLIT_CNT;
      end
    end
  end

endmodule

// File: tb/tb_ts_readout_arbiter.sv
// Directed bench for ts_readout_arbiter: FIFO source models, a per-cycle output checker and
// per-test expected write sequences derived from the round-robin / record rules.
module tb_ts_readout_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  src_en, src_empty, src_read;
  logic [N*DW-1:0] src_data;
  logic          out_full, out_write, busy;
  logic [DW-1:0] out_data;
  logic [2:0]    grant_id;
  logic [7:0]    split_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] srcq [N][$];
  logic [31:0] out_log[$];
  logic [31:0] exp_log[$];
  logic [N-1:0] prev_rd;
  logic [31:0]  prev_word;

  ts_readout_arbiter dut (
    .BUS_CLK   (clk),
    .BUS_RST   (rst),
    .SRC_EN    (src_en),
    .SRC_EMPTY (src_empty),
    .SRC_DATA  (src_data),
    .SRC_READ  (src_read),
    .OUT_FULL  (out_full),
    .OUT_WRITE (out_write),
    .OUT_DATA  (out_data),
    .GRANT_ID  (grant_id),
    .BUSY      (busy),
    .SPLIT_CNT (split_cnt)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] wd(input int s, input int n);
    return {8'(s), 8'hA5, 16'(n)};
  endfunction

  task automatic load(input int s, input int start, input int n);
    for (int k = 0; k < n; k++) srcq[s].push_back(wd(s, start + k));
  endtask

  task automatic exp_add(input int s, input int start, input int n);
    for (int k = 0; k < n; k++) exp_log.push_back(wd(s, start + k));
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      src_empty[i] = (srcq[i].size() == 0);
      src_data[i*DW +: DW] = (srcq[i].size() != 0) ? srcq[i][0] : 32'hDEAD_0000;
    end
  endtask

  // One clock: sample pops before the edge, retire them from the source FIFOs after it.
  task automatic cycle();
    logic [N-1:0] pop;
    drive();
    #1;
    pop = src_read;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (pop[i] && srcq[i].size() != 0) void'(srcq[i].pop_front());
    drive();
    #1;
  endtask

  task automatic drain(input string name, input int budget);
    logic done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      cycle();
      done = !busy && !out_write;
      for (int i = 0; i < N; i++) done = done && (srcq[i].size() == 0);
    end
    check({name, "_drained"}, 32'(done), 32'd1);
    repeat (2) cycle();
  endtask

  task automatic compare_log(input string name);
    check({name, "_count"}, 32'(out_log.size()), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < out_log.size(); i++)
      check({name, "_word"}, out_log[i], exp_log[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) srcq[i].delete();
    drive();
    repeat (2) cycle();
    rst = 1'b0;
    out_log.delete();
    exp_log.delete();
  endtask

  // Every cycle: a write follows each pop by one clock with the popped word; pops must be legal.
  always @(negedge clk) begin
    logic legal;
    if (rst) begin
      prev_rd = '0;
    end else begin
      check("write_follows_read", 32'(out_write), 32'(|prev_rd));
      if (|prev_rd) begin
        check("write_data", out_data, prev_word);
        out_log.push_back(out_data);
      end
      legal = (src_read == '0) ||
              ((src_read == (4'b0001 << grant_id)) && busy && !out_full &&
               ((src_read & src_en & ~src_empty) != '0));
      check("read_legal", 32'(legal), 32'd1);
      prev_rd = src_read;
      for (int i = 0; i < N; i++) if (src_read[i]) prev_word = src_data[i*DW +: DW];
    end
  end

  initial begin
    rst      = 1'b1;
    src_en   = '1;
    out_full = 1'b0;
    prev_rd  = '0;
    prev_word = '0;
    srcq[1].push_back(wd(1, 0));
    drive();
    repeat (2) cycle();
    check("rst_out_write", 32'(out_write), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_split", 32'(split_cnt), 32'd0);
    check("rst_src_read", 32'(src_read), 32'd0);

    // Single source with six words.
    do_reset();
    load(2, 0, 6);
    exp_add(2, 0, 6);
    cycle();
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_grant_id", 32'(grant_id), 32'd2);
    check("t1_no_write_yet", 32'(out_write), 32'd0);
    cycle();
    check("t1_first_write", 32'(out_write), 32'd1);
    check("t1_first_data", out_data, 32'h02A5_0000);
    drain("t1", 50);
    compare_log("t1");
    check("t1_split", 32'(split_cnt), 32'd0);
    check("t1_grant_kept", 32'(grant_id), 32'd2);

    // Fairness: 40 words per source, bursts of 16, 16, 8 in order 0..3.
    do_reset();
    for (int s = 0; s < N; s++) load(s, 0, 40);
    for (int r = 0; r < 3; r++)
      for (int s = 0; s < N; s++) exp_add(s, r * 16, (r < 2) ? 16 : 8);
    drain("t2", 400);
    check("t2_total", 32'(out_log.size()), 32'd160);
    compare_log("t2");
    check("t2_split", 32'(split_cnt), 32'd0);

    // Mid-record empty: source 1 holds its grant while source 0 waits.
    do_reset();
    srcq[1].push_back(wd(1, 0));
    exp_add(1, 0, 2);
    exp_add(0, 0, 2);
    repeat (2) cycle();
    load(0, 0, 2);
    cycle();
    check("t3_hold_busy", 32'(busy), 32'd1);
    check("t3_hold_grant", 32'(grant_id), 32'd1);
    check("t3_hold_no_read", 32'(src_read), 32'd0);
    repeat (4) cycle();
    srcq[1].push_back(wd(1, 1));
    drive();
    #1;
    check("t3_resume_read", 32'(src_read), 32'd2);
    drain("t3", 50);
    compare_log("t3");
    check("t3_split", 32'(split_cnt), 32'd0);

    // Hold timeout: lone word from source 1, release 256 cycles after entering HOLD.
    do_reset();
    srcq[1].push_back(wd(1, 0));
    exp_add(1, 0, 1);
    exp_add(2, 0, 2);
    exp_add(0, 0, 2);
    repeat (3) cycle();
    load(0, 0, 2);
    load(2, 0, 2);
    check("t4_hold_entered", 32'(busy), 32'd1);
    repeat (255) cycle();
    check("t4_still_holding", 32'(busy), 32'd1);
    check("t4_split_before", 32'(split_cnt), 32'd0);
    cycle();
    check("t4_released", 32'(busy), 32'd0);
    check("t4_split_after", 32'(split_cnt), 32'd1);
    cycle();
    check("t4_next_grant", 32'(grant_id), 32'd2);
    drain("t4", 50);
    compare_log("t4");

    // Backpressure: OUT_FULL high for 10 cycles during a burst.
    do_reset();
    load(0, 0, 12);
    exp_add(0, 0, 12);
    repeat (3) cycle();
    for (int k = 0; k < 10; k++) begin
      out_full = 1'b1;
      #1;
      check("t5_stall_read", 32'(src_read), 32'd0);
      if (k > 0) check("t5_stall_write", 32'(out_write), 32'd0);
      check("t5_stall_busy", 32'(busy), 32'd1);
      cycle();
    end
    out_full = 1'b0;
    #1;
    check("t5_resume_read", 32'(src_read), 32'd1);
    drain("t5", 50);
    compare_log("t5");
    check("t5_split", 32'(split_cnt), 32'd0);

    // Asynchronous reset mid-burst, then arbitration restarts at source 0.
    out_log.delete();
    exp_log.delete();
    load(2, 0, 10);
    repeat (4) cycle();
    check("t6_pre_write", 32'(out_write), 32'd1);
    check("t6_pre_grant", 32'(grant_id), 32'd2);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_write", 32'(out_write), 32'd0);
    check("t6_rst_data", out_data, 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_read", 32'(src_read), 32'd0);
    check("t6_rst_grant", 32'(grant_id), 32'd0);
    for (int i = 0; i < N; i++) srcq[i].delete();
    drive();
    repeat (2) cycle();
    rst = 1'b0;
    out_log.delete();
    load(0, 0, 2);
    load(3, 0, 2);
    exp_add(0, 0, 2);
    exp_add(3, 0, 2);
    cycle();
    check("t6_restart_grant", 32'(grant_id), 32'd0);
    check("t6_restart_busy", 32'(busy), 32'd1);
    drain("t6", 50);
    compare_log("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
